// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - registered N-channel valid/ready mux with fixed-select or round-robin grant
module arb_mux_n #(
   parameter int n    = 32,
   parameter int ch   = 4,
   parameter int selw = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ch*n-1:0]   in_data,
   input  logic [ch-1:0]     in_valid,
   output logic [ch-1:0]     in_ready,
   input  logic              mode,
   input  logic [selw-1:0]   sel,
   output logic [n-1:0]      out_data,
   output logic [selw-1:0]   out_chan,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int np = 1 << selw;

   logic [selw-1:0] last;
   logic [np-1:0]   valid_pad;
   logic [selw-1:0] rr_gnt;
   logic [selw-1:0] idx;
   logic            rr_valid;
   logic            fx_valid;
   logic [selw-1:0] gnt;
   logic            grant_valid;
   logic            load;
   logic [n-1:0]    sel_data;

   // Zero-padding to the full index space makes any sel >= ch see an idle channel.
   assign valid_pad = np'(in_valid);
   assign fx_valid  = valid_pad[sel];

   // Walk from farthest to nearest so the nearest requester after last wins.
   always_comb begin
      rr_valid = 1'b0;
      rr_gnt   = '0;
      idx      = '0;
      for (int k = ch; k >= 1; k--) begin
         idx = selw'((int'(last) + k) % ch);
         if (valid_pad[idx]) begin
            rr_valid = 1'b1;
            rr_gnt   = idx;
         end
      end
   end

   assign gnt         = mode ? rr_gnt : sel;
   assign grant_valid = ~reset & (mode ? rr_valid : fx_valid);
   assign load        = ~out_valid | out_ready;

   always_comb begin
      in_ready = '0;
      sel_data = '0;
      for (int i = 0; i < ch; i++) begin
         in_ready[i] = load & grant_valid & (int'(gnt) == i);
         if (int'(gnt) == i)
            sel_data = in_data[i*n +: n];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         last      <= selw'(ch - 1);
      end else if (|in_ready) begin
         out_data  <= sel_data;
         out_chan  <= gnt;
         out_valid <= 1'b1;
         if (mode)
            last <= gnt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - randomized and directed bench for arb_mux_n against a behavioural model
module tb_arb_mux_n;
   localparam int N  = 32;
   localparam int CH = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [CH*N-1:0] in_data;
   logic [CH-1:0]   in_valid;
   logic [CH-1:0]   in_ready;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [N-1:0]    out_data;
   logic [SW-1:0]   out_chan;
   logic            out_valid;
   logic            out_ready;

   logic [23:0]     d3_data;
   logic [2:0]      d3_valid;
   logic [2:0]      d3_ready;
   logic [1:0]      d3_sel;
   logic [7:0]      d3_out;
   logic [1:0]      d3_chan;
   logic            d3_ov;

   arb_mux_n #(.n(N), .ch(CH), .selw(SW)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
   );

   arb_mux_n #(.n(8), .ch(3), .selw(2)) dut3 (
      .clk(clk), .reset(reset), .in_data(d3_data), .in_valid(d3_valid),
      .in_ready(d3_ready), .mode(1'b0), .sel(d3_sel), .out_data(d3_out),
      .out_chan(d3_chan), .out_valid(d3_ov), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   bit          m_valid = 1'b0;
   logic [N-1:0] m_data = '0;
   int          m_chan  = 0;
   int          m_last  = CH - 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Grant per the rules: fixed picks sel if it requests, round-robin picks the
   // first requester after the last round-robin winner; -1 means nobody.
   function automatic int model_grant();
      int g = -1;
      if (reset) return -1;
      if (!mode) begin
         if (int'(sel) < CH && in_valid[sel]) g = int'(sel);
      end else begin
         for (int k = 1; k <= CH; k++) begin
            int c = (m_last + k) % CH;
            if (in_valid[c]) begin
               g = c;
               break;
            end
         end
      end
      if (m_valid && !out_ready) g = -1;
      return g;
   endfunction

   // Inputs are driven at the falling edge; one call covers one rising edge.
   task automatic step(input string tag);
      int g;
      #1;
      g = model_grant();
      check({tag, ".in_ready"}, 64'(in_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0; m_data = '0; m_chan = 0; m_last = CH - 1;
      end else if (g >= 0) begin
         m_valid = 1'b1; m_data = in_data[g*N +: N]; m_chan = g;
         if (mode) m_last = g;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
      check({tag, ".out_data"},  64'(out_data),  64'(m_data));
      check({tag, ".out_chan"},  64'(out_chan),  64'(m_chan));
   endtask

   task automatic rand_data();
      for (int i = 0; i < CH; i++) in_data[i*N +: N] = $urandom;
   endtask

   logic [N-1:0] held;
   int           exp_seq [4] = '{3, 1, 3, 1};

   initial begin
      reset = 1'b1; mode = 1'b1; sel = '0; out_ready = 1'b1;
      in_valid = '1; rand_data();
      d3_data = 24'hA5C33C; d3_valid = '0; d3_sel = '0;

      step("reset");
      check("reset.out_valid", 64'(out_valid), 64'd0);
      check("reset.out_chan",  64'(out_chan),  64'd0);
      check("reset.out_data",  64'(out_data),  64'd0);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         rand_data();
         step("rr_all");
         check("rr_all.seq",   64'(out_chan),  64'(i % 4));
         check("rr_all.valid", 64'(out_valid), 64'd1);
      end

      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         step("rr_odd");
         check("rr_odd.seq", 64'(out_chan), 64'(exp_seq[i]));
      end

      reset = 1'b1; step("reset2"); reset = 1'b0;
      mode = 1'b0; sel = 2'd2; in_valid = 4'b0111; rand_data();
      in_data[2*N +: N] = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         step("fixed");
         check("fixed.in_ready", 64'(in_ready), 64'b0100);
         check("fixed.data",     64'(out_data), 64'hDEADBEEF);
         check("fixed.chan",     64'(out_chan), 64'd2);
      end
      mode = 1'b1; in_valid = 4'b1111;
      step("ptr_kept");
      check("ptr_kept.chan", 64'(out_chan), 64'd0);

      out_ready = 1'b0; held = out_data;
      for (int i = 0; i < 3; i++) begin
         rand_data();
         step("stall");
         check("stall.in_ready", 64'(in_ready), 64'd0);
         check("stall.data",     64'(out_data), 64'(held));
      end
      out_ready = 1'b1;
      step("unstall");
      check("unstall.valid", 64'(out_valid), 64'd1);
      check("unstall.chan",  64'(out_chan),  64'd1);

      in_valid = '0; held = out_data;
      step("drain");
      check("drain.valid", 64'(out_valid), 64'd0);
      check("drain.data",  64'(out_data),  64'(held));

      in_valid = 4'b0100; step("load1");
      out_ready = 1'b0; reset = 1'b1; in_valid = '1;
      step("reset_mid");
      check("reset_mid.valid", 64'(out_valid), 64'd0);
      check("reset_mid.chan",  64'(out_chan),  64'd0);
      reset = 1'b0; out_ready = 1'b1; rand_data();
      step("after_reset");
      check("after_reset.chan", 64'(out_chan), 64'd0);

      d3_valid = 3'b111; d3_sel = 2'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ch3_sel3.ready", 64'(d3_ready), 64'd0);
         @(posedge clk); @(negedge clk);
         check("ch3_sel3.valid", 64'(d3_ov), 64'd0);
      end
      d3_sel = 2'd1; #1;
      check("ch3_sel1.ready", 64'(d3_ready), 64'b010);
      @(negedge clk);

      for (int i = 0; i < 500; i++) begin
         reset     = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 7) == 0) mode = $urandom;
         sel       = $urandom;
         in_valid  = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         step("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised, registered N-channel data multiplexer with per-channel valid/ready handshakes.
- Replaces the purely combinational select muxes wherever a shared resource takes requests from several producers, e.g. the writeback port or a memory-request port.
- Two selection modes:
  - fixed select: the channel is chosen by the sel input.
  - round-robin arbitration: fair rotation among requesting channels.
- One output register stage provides a registered result, the granted channel id and full-throughput back-pressure.

Parameters:
- n, 32, data width per channel in bits.
- ch, 4, number of input channels (≥2).
- selw, 2, channel-index width; must satisfy 2^selw ≥ ch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  ch*n  channel i data occupies bits [i*n +: n].
- in_valid  input  ch  channel i presents a request.
- in_ready  output  ch  channel i request accepted this cycle (combinational).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  selw  channel to pass in fixed mode; ignored in round-robin mode.
- out_data  output  n  registered selected data.
- out_chan  output  selw  registered index of the channel that produced out_data.
- out_valid  output  1  out_data/out_chan hold an unconsumed item.
- out_ready  input  1  consumer accepts the output item this cycle.

Behaviour:
- Reset (reset=1 at clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=ch-1, so channel 0 has highest priority first.
  - in_ready is all-zero while reset is high.
- load = ~out_valid | out_ready. The output register can accept a new item this cycle.
- Grant, fixed mode (mode=0):
  - gnt = sel when in_valid[sel]=1 and sel<ch; otherwise no grant.
  - sel ≥ ch grants nothing and never loads.
- Grant, round-robin mode (mode=1):
  - Search channels last+1, last+2, … mod ch.
  - The first channel with in_valid=1 is granted.
- in_ready[i] = load & grant_valid & (gnt==i). At most one bit is set; combinational from in_valid, sel, mode and out_ready.
- Transfer: on a clk edge with in_ready[gnt]=1:
  - out_data ← in_data[gnt].
  - out_chan ← gnt.
  - out_valid ← 1.
  - In round-robin mode, last ← gnt.
- Fixed-mode transfers do not move the round-robin pointer.
- Drain without refill: out_valid=1, out_ready=1, no grant → out_valid ← 0. out_data and out_chan hold their last values.
- Stall: out_valid=1, out_ready=0 → out_data, out_chan and out_valid hold; all in_ready=0.
- Simultaneous drain and refill: out_valid=1, out_ready=1, grant present → the new item loads in the same edge. Sustained throughput is 1 item/cycle with no bubble.
- Latency: an input accepted at edge k is visible on the outputs immediately after edge k (1 cycle).
- Pointer wrap: after granting ch-1, the search starts at 0.
- No requests: no grant, pointer unchanged.
- Mode switch: takes effect on the grant in the same cycle mode changes. The item in the output register is unaffected. The pointer is preserved across fixed-mode intervals.
- Reset mid-operation: a pending output item is discarded (out_valid=0) and the pointer returns to ch-1. No in_ready is asserted in that cycle.
- Input contract: a producer holds in_valid and in_data stable until it sees in_ready. The block does not enforce this.

Test Plan:
- Reset, then mode=1, in_valid=4'b1111, out_ready=1 held:
  - grants go 0,1,2,3,0,… on consecutive cycles.
  - out_chan follows one cycle later.
  - out_data=in_data of each channel; out_valid continuously 1.
- mode=1, in_valid=4'b1010, out_ready=1: grants alternate 1,3,1,3 and channels 0 and 2 never receive in_ready.
- mode=0, sel=2, in_valid=4'b0111, ch2 data=32'hDEADBEEF:
  - in_ready=4'b0100 every cycle.
  - out_data=32'hDEADBEEF, out_chan=2, and the pointer stays unchanged (check by switching to mode=1: first grant is channel 0 after reset).
- Back-pressure: one item loaded, out_ready=0 for 3 cycles while all channels request:
  - in_ready=0 throughout; out_data stable.
  - When out_ready goes to 1, the next item loads the same cycle with no bubble.
- Drain: out_valid=1, out_ready=1, in_valid=0 → out_valid drops to 0 next cycle, out_data retains its value. sel=3 with ch=3 (parameter override) → no grant ever.
- Assert reset while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_chan=0. The next round-robin grant with all channels valid is channel 0.
